// File: rtl/conv1d_2nd_ram_ctrl.sv
// Layer-2 CONV1D data RAM sequencer: channel-major fill, then Num_Passes position-major sweeps; writes and reads issue one cycle after accept/issue, taps one cycle after that.
// mac_stall holds read issue; in_ready only in FILL. Optional stall counter: CONV1D_CTRL_STALL_CNT_EN.
module conv1d_2nd_ram_ctrl #(
   parameter int Bit_width    = 16,
   parameter int RAM_Depth    = 256,
   parameter int Num_Channels = 8,
   parameter int Num_Passes   = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [Bit_width-1:0] in_data,
   output logic                 ram_write_enable,
   output logic [2:0]           ram_write_depth,
   output logic [7:0]           ram_write_width,
   output logic [Bit_width-1:0] ram_data_in,
   output logic                 ram_read_enable,
   output logic [2:0]           ram_read_depth,
   output logic [7:0]           ram_read_width,
   input  logic                 mac_stall,
   output logic                 tap_valid,
   output logic [2:0]           tap_depth,
   output logic [7:0]           tap_width,
   output logic                 tap_last,
   output logic [7:0]           pass_idx,
   output logic                 busy,
   output logic                 sweep_done,
   output logic [15:0]          stall_cycles
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FILL  = 3'd1;
   localparam logic [2:0] FLUSH = 3'd2;
   localparam logic [2:0] SWEEP = 3'd3;
   localparam logic [2:0] DRAIN = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [7:0] LAST_POS  = 8'(RAM_Depth - 1);
   localparam logic [2:0] LAST_CH   = 3'(Num_Channels - 1);
   localparam logic [7:0] LAST_PASS = 8'(Num_Passes - 1);

   logic [2:0] state;
   logic [2:0] wr_ch;
   logic [7:0] wr_pos;
   logic [2:0] rd_ch;
   logic [7:0] rd_pos;
   logic [7:0] rd_pass;
   logic       issue_done;
   logic       accept;
   logic       issue;
   logic       last_wr;
   logic       last_rd_addr;
   logic       cur_pass_end;

   assign in_ready     = (state == FILL);
   assign busy         = (state != IDLE);
   assign accept       = in_ready && in_valid;
   assign last_wr      = (wr_ch == LAST_CH) && (wr_pos == LAST_POS);
   assign issue        = (state == SWEEP) && !issue_done && !mac_stall;
   assign last_rd_addr = (rd_ch == LAST_CH) && (rd_pos == LAST_POS);
   // pass_idx follows the read actually on the RAM port, one cycle behind the issue counters
   assign cur_pass_end = ram_read_enable && (ram_read_depth == LAST_CH) && (ram_read_width == LAST_POS);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= IDLE;
         wr_ch            <= '0;
         wr_pos           <= '0;
         rd_ch            <= '0;
         rd_pos           <= '0;
         rd_pass          <= '0;
         issue_done       <= 1'b0;
         ram_write_enable <= 1'b0;
         ram_write_depth  <= '0;
         ram_write_width  <= '0;
         ram_data_in      <= '0;
         ram_read_enable  <= 1'b0;
         ram_read_depth   <= '0;
         ram_read_width   <= '0;
         tap_valid        <= 1'b0;
         tap_depth        <= '0;
         tap_width        <= '0;
         tap_last         <= 1'b0;
         pass_idx         <= '0;
         sweep_done       <= 1'b0;
      end else begin
         ram_write_enable <= accept;
         ram_read_enable  <= issue;
         tap_valid        <= ram_read_enable;
         tap_last         <= ram_read_enable && (ram_read_depth == LAST_CH);
         sweep_done       <= (state == DRAIN);
         if (ram_read_enable) begin
            tap_depth <= ram_read_depth;
            tap_width <= ram_read_width;
         end

         if (accept) begin
            ram_write_depth <= wr_ch;
            ram_write_width <= wr_pos;
            ram_data_in     <= in_data;
            if (wr_pos == LAST_POS) begin
               wr_pos <= '0;
               wr_ch  <= wr_ch + 3'd1;
            end else begin
               wr_pos <= wr_pos + 8'd1;
            end
         end

         if (issue) begin
            ram_read_depth <= rd_ch;
            ram_read_width <= rd_pos;
            if (last_rd_addr) begin
               rd_ch  <= '0;
               rd_pos <= '0;
               if (rd_pass == LAST_PASS) issue_done <= 1'b1;
               else                      rd_pass    <= rd_pass + 8'd1;
            end else if (rd_ch == LAST_CH) begin
               rd_ch  <= '0;
               rd_pos <= rd_pos + 8'd1;
            end else begin
               rd_ch <= rd_ch + 3'd1;
            end
         end

         if (cur_pass_end && (pass_idx != LAST_PASS)) pass_idx <= pass_idx + 8'd1;

         case (state)
            IDLE: begin
               if (start) begin
                  state      <= FILL;
                  wr_ch      <= '0;
                  wr_pos     <= '0;
                  rd_ch      <= '0;
                  rd_pos     <= '0;
                  rd_pass    <= '0;
                  issue_done <= 1'b0;
                  pass_idx   <= '0;
               end
            end
            FILL:    if (accept && last_wr) state <= FLUSH;
            FLUSH:   state <= SWEEP;
            SWEEP:   if (cur_pass_end && (pass_idx == LAST_PASS)) state <= DRAIN;
            DRAIN:   state <= DONE;
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CONV1D_CTRL_STALL_CNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge CLK) begin
      if (RST)
         stall_cnt <= '0;
      else if ((state == IDLE) && start)
         stall_cnt <= '0;
      else if ((state == SWEEP) && mac_stall && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign stall_cycles = stall_cnt;
`else
   assign stall_cycles = 16'h0000;
`endif

endmodule
